// File: rtl/prio_req_tracker_if.sv
// Request/acknowledge bus between event sources, the tracker and its consumer.
// The master side drives requests and acknowledges; the slave side (the tracker)
// returns the pending state, selected index and drop count.
interface prio_req_tracker_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         ack;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] pending;
  logic [7:0]   drop_cnt;

  modport master (
    output req, ack,
    input  valid, idx, pending, drop_cnt
  );

  modport slave (
    input  req, ack,
    output valid, idx, pending, drop_cnt
  );
endinterface

// File: rtl/prio_req_tracker.sv
// prio_req_tracker: latches N request lines into a pending register, presents
// the winning pending index with a valid flag, and retires it on ack.
// Requests that land on an already-pending line (and are not being retired that
// cycle) are counted in a saturating 8-bit drop counter.
// Optional build macro PRIO_ROUND_ROBIN_EN: adds a rotating search pointer so
// the search starts just below the last retired index, giving fairness under
// sustained load. Without it the highest set index always wins.
module prio_req_tracker #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prio_req_tracker_if.slave     bus
);
  localparam int W = $clog2(N);

  logic [N-1:0] pending_q;
  logic [7:0]   drop_q;
  logic [W-1:0] idx_sel;
  logic [N-1:0] clr;
  logic         take;
  logic         drop_now;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [W-1:0] ptr;

  // Search downward from ptr, wrapping 0 -> N-1; smallest distance from ptr wins.
  always_comb begin
    int pos;
    pos     = 0;
    idx_sel = '0;
    for (int o = N - 1; o >= 0; o--) begin
      pos = int'(ptr) - o;
      if (pos < 0) pos = pos + N;
      if (pending_q[pos]) idx_sel = W'(pos);
    end
  end

  // Move the pointer just below the index being retired.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (take) begin
      ptr <= (idx_sel == '0) ? W'(N - 1) : idx_sel - 1'b1;
    end
  end
`else
  // Fixed priority: the highest set pending bit wins; 0 when nothing is pending.
  always_comb begin
    idx_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) idx_sel = W'(i);
    end
  end
`endif

  // Retire the presented index only when something is actually pending.
  always_comb begin
    take = (|pending_q) && bus.ack;
    clr  = '0;
    if (take) clr[idx_sel] = 1'b1;
    drop_now = |(bus.req & pending_q & ~clr);
  end

  // Pending register: new requests win over a same-cycle clear of the same bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | bus.req;
    end
  end

  // Count cycles with at least one lost request, saturating at 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_now && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.valid    = |pending_q;
  assign bus.idx      = idx_sel;
  assign bus.pending  = pending_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_prio_req_tracker.sv
// Directed testbench for prio_req_tracker (N = 8). Expected values are
// hand-computed; a few expectations differ when PRIO_ROUND_ROBIN_EN is defined.
module tb_prio_req_tracker;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  prio_req_tracker_if #(.N(8)) bus ();

  prio_req_tracker #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive req/ack for one cycle and land 1 ns after the clock edge.
  task automatic applyStimulus(input logic [7:0] r, input logic a);
    bus.req = r;
    bus.ack = a;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence.
  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.ack = 1'b0;

    // Reset with req/ack active: everything must come out cleared.
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    checkOutput("rst_pending", 64'(bus.pending), 64'h0);
    checkOutput("rst_valid", 64'(bus.valid), 64'h0);
    checkOutput("rst_idx", 64'(bus.idx), 64'h0);
    checkOutput("rst_drop", 64'(bus.drop_cnt), 64'h0);
`ifdef PRIO_ROUND_ROBIN_EN
    checkOutput("rst_ptr", 64'(dut.ptr), 64'h7);
`endif
    rst_n = 1'b1;

    // Post 0x14 and retire both entries.
    applyStimulus(8'h14, 1'b0);
    checkOutput("post_pending", 64'(bus.pending), 64'h14);
    checkOutput("post_valid", 64'(bus.valid), 64'h1);
    checkOutput("post_idx", 64'(bus.idx), 64'h4);
    applyStimulus(8'h00, 1'b1);
    checkOutput("ack1_idx", 64'(bus.idx), 64'h2);
    checkOutput("ack1_pending", 64'(bus.pending), 64'h04);
    applyStimulus(8'h00, 1'b1);
    checkOutput("ack2_valid", 64'(bus.valid), 64'h0);
    checkOutput("ack2_idx", 64'(bus.idx), 64'h0);

    // Ack with nothing pending has no effect.
    applyStimulus(8'h00, 1'b1);
    checkOutput("idle_ack_pending", 64'(bus.pending), 64'h0);
    checkOutput("idle_ack_drop", 64'(bus.drop_cnt), 64'h0);
`ifdef PRIO_ROUND_ROBIN_EN
    checkOutput("idle_ack_ptr", 64'(dut.ptr), 64'h1);
`endif

    // Drop on an already-pending line.
    applyStimulus(8'h10, 1'b0);
    checkOutput("drop_setup_drop", 64'(bus.drop_cnt), 64'h0);
    checkOutput("drop_setup_idx", 64'(bus.idx), 64'h4);
    applyStimulus(8'h10, 1'b0);
    checkOutput("drop_cnt1", 64'(bus.drop_cnt), 64'h1);
    checkOutput("drop_pending", 64'(bus.pending), 64'h10);

    // Same request with ack on that index: set wins, no drop.
    applyStimulus(8'h10, 1'b1);
    checkOutput("setclr_pending", 64'(bus.pending), 64'h10);
    checkOutput("setclr_drop", 64'(bus.drop_cnt), 64'h1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("clear_pending", 64'(bus.pending), 64'h0);

    // Build pending=0xA5, drop=3, then reset mid-operation with req=0xFF.
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'hA5, 1'b0);
    checkOutput("pre_rst_pending", 64'(bus.pending), 64'hA5);
    checkOutput("pre_rst_drop", 64'(bus.drop_cnt), 64'h3);
    rst_n = 1'b0;
    applyStimulus(8'hFF, 1'b0);
    rst_n = 1'b1;
    checkOutput("midrst_pending", 64'(bus.pending), 64'h0);
    checkOutput("midrst_valid", 64'(bus.valid), 64'h0);
    checkOutput("midrst_drop", 64'(bus.drop_cnt), 64'h0);
`ifdef PRIO_ROUND_ROBIN_EN
    checkOutput("midrst_ptr", 64'(dut.ptr), 64'h7);
`endif

    // Sustained 0x81 with ack every cycle: fixed stays on 7, round-robin alternates.
    applyStimulus(8'h81, 1'b0);
    checkOutput("rr_idx_start", 64'(bus.idx), 64'h7);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'h81, 1'b1);
`ifdef PRIO_ROUND_ROBIN_EN
      checkOutput($sformatf("rr_idx_%0d", k), 64'(bus.idx), (k % 2 == 0) ? 64'h0 : 64'h7);
`else
      checkOutput($sformatf("fix_idx_%0d", k), 64'(bus.idx), 64'h7);
`endif
    end
    checkOutput("rr_drop", 64'(bus.drop_cnt), 64'h4);

    // Saturation: hold 0xFF for 300 cycles from empty.
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(8'hFF, 1'b0);
      if (k == 255) checkOutput("sat_254", 64'(bus.drop_cnt), 64'd254);
      if (k == 256) checkOutput("sat_255", 64'(bus.drop_cnt), 64'd255);
    end
    checkOutput("sat_hold", 64'(bus.drop_cnt), 64'd255);
    checkOutput("sat_pending", 64'(bus.pending), 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
